// File: rtl/riscv_pkg.sv
// Shared core types and widths.
// Register-file entry format for write-back.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries.
// Extra pointer MSB separates full from empty.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  wb_entry_t   mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer advance on accepted push/pop.
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: W stage first,
// buffered long-latency results fill idle slots.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_wd,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_wd,
  output logic [REG_AW-1:0] a3,
  output logic              we3,
  output logic [XLEN-1:0]   wd3,
  output logic [31:0]       busy_vec,
  output logic              stall_req
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

  logic      full;
  logic      empty;
  wb_entry_t head;
  wb_entry_t din;
  logic      push;
  logic      pop;
  logic      slot_busy;

  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_q, stall_d;

  assign slot_busy = pipe_we && (pipe_rd != '0);
  assign lu_ready  = !full;
  // x0 results complete the handshake but are dropped.
  assign push      = lu_valid && lu_ready && (lu_rd != '0);
  assign pop       = !slot_busy && !empty;
  assign din       = '{rd: lu_rd, wd: lu_wd};
  assign busy_vec  = busy_q;
  assign stall_req = stall_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // Write-port mux: pipe slot wins, else FIFO head.
  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (slot_busy) begin
      we3 = 1'b1;
      a3  = pipe_rd;
      wd3 = pipe_wd;
    end else if (pop) begin
      we3 = 1'b1;
      a3  = head.rd;
      wd3 = head.wd;
    end
  end

  // Scoreboard, starvation count and stall request.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (issue_valid && issue_rd != '0)
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (pop || empty)
      cnt_d = '0;
    else if (slot_busy && cnt_q != CMAX)
      cnt_d = cnt_q + 1'b1;

    stall_d = stall_q;
    if (pop)
      stall_d = 1'b0;
    else if (cnt_q == CMAX)
      stall_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue model plus
// directed scenarios with literal expectations.
module tb_wb_arbiter;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic [4:0]  a3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] busy_vec;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_we     (pipe_we),
    .pipe_rd     (pipe_rd),
    .pipe_wd     (pipe_wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_wd       (lu_wd),
    .a3          (a3),
    .we3         (we3),
    .wd3         (wd3),
    .busy_vec    (busy_vec),
    .stall_req   (stall_req)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Model state: pending results in order, busy bits,
  // length of the current blocked run, stall flag.
  wb_entry_t   mq[$];
  bit          mbusy [32];
  int          mrun;
  bit          mstall;

  always @(negedge clk) begin
    bit          slot;
    bit          pop;
    logic [31:0] ebusy;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ewd;
    wb_entry_t   h;
    if (!rst_n) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 0;
      mrun   = 0;
      mstall = 0;
    end
    slot = pipe_we && pipe_rd != 0;
    pop  = !slot && mq.size() > 0;
    ewe = 0; ea = 0; ewd = 0;
    if (slot) begin
      ewe = 1; ea = pipe_rd; ewd = pipe_wd;
    end else if (pop) begin
      h = mq[0];
      ewe = 1; ea = h.rd; ewd = h.wd;
    end
    ebusy = 0;
    for (int i = 1; i < 32; i++) ebusy[i] = mbusy[i];
    chk("m_we3", 32'(we3), 32'(ewe));
    chk("m_a3", 32'(a3), 32'(ea));
    chk("m_wd3", wd3, ewd);
    chk("m_ready", 32'(lu_ready),
        32'(mq.size() < DEPTH));
    chk("m_busy", busy_vec, ebusy);
    chk("m_stall", 32'(stall_req), 32'(mstall));
    if (rst_n) begin
      if (pop) mstall = 0;
      else if (mrun >= SMAX) mstall = 1;
      if (pop || mq.size() == 0) mrun = 0;
      else if (slot) mrun++;
      if (pop) begin
        h = mq.pop_front();
        mbusy[h.rd] = 0;
      end
      if (issue_valid && issue_rd != 0)
        mbusy[issue_rd] = 1;
      if (lu_valid && lu_ready && lu_rd != 0)
        mq.push_back('{rd: lu_rd, wd: lu_wd});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    issue_valid = 0; issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_wd = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_ready", 32'(lu_ready), 32'd1);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_we3", 32'(we3), 32'd0);

    // Idle pipe: x5 result drains the next cycle.
    step();
    issue_valid = 1; issue_rd = 5;
    step();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5; lu_wd = 32'hDEADBEEF;
    #1;
    chk("s1_ready", 32'(lu_ready), 32'd1);
    chk("s1_nobyp", 32'(we3), 32'd0);
    step();
    lu_valid = 0;
    #1;
    chk("s1_we3", 32'(we3), 32'd1);
    chk("s1_a3", 32'(a3), 32'd5);
    chk("s1_wd3", wd3, 32'hDEADBEEF);
    chk("s1_busy5", 32'(busy_vec[5]), 32'd1);
    step();
    #1;
    chk("s1_clr", busy_vec, 32'd0);
    chk("s1_we3off", 32'(we3), 32'd0);

    // Pipe priority with two queued results.
    pipe_we = 1; pipe_rd = 3; pipe_wd = 32'h11;
    issue_valid = 1; issue_rd = 6;
    step();
    issue_rd = 7;
    lu_valid = 1; lu_rd = 6; lu_wd = 32'h66;
    step();
    issue_valid = 0;
    lu_rd = 7; lu_wd = 32'h77;
    #1;
    chk("s2_ready1", 32'(lu_ready), 32'd1);
    chk("s2_a3", 32'(a3), 32'd3);
    step();
    lu_valid = 0;
    #1;
    chk("s2_full", 32'(lu_ready), 32'd0);
    chk("s2_wd3", wd3, 32'h11);
    step();
    step();
    step();
    #1;
    chk("s2_nostall", 32'(stall_req), 32'd0);
    step();
    #1;
    chk("s2_stall", 32'(stall_req), 32'd1);
    step();
    pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    #1;
    chk("s2_pop6", 32'(a3), 32'd6);
    chk("s2_wd6", wd3, 32'h66);
    chk("s2_hold", 32'(stall_req), 32'd1);
    step();
    #1;
    chk("s2_pop7", 32'(a3), 32'd7);
    chk("s2_drop", 32'(stall_req), 32'd0);
    step();
    #1;
    chk("s2_done", busy_vec, 32'd0);

    // x0 handling.
    lu_valid = 1; lu_rd = 0; lu_wd = 32'hBAD;
    issue_valid = 1; issue_rd = 0;
    #1;
    chk("x0_ready", 32'(lu_ready), 32'd1);
    step();
    idle();
    #1;
    chk("x0_we3", 32'(we3), 32'd0);
    chk("x0_busy", busy_vec, 32'd0);
    issue_valid = 1; issue_rd = 4;
    lu_valid = 1; lu_rd = 4; lu_wd = 32'h44;
    step();
    idle();
    pipe_we = 1; pipe_rd = 0; pipe_wd = 32'h55;
    #1;
    chk("x0_drain", 32'(a3), 32'd4);
    chk("x0_wd", wd3, 32'h44);
    step();
    idle();

    // Set and clear on the same bit: set wins.
    issue_valid = 1; issue_rd = 9;
    lu_valid = 1; lu_rd = 9; lu_wd = 32'h99;
    step();
    lu_valid = 0;
    #1;
    chk("col_pop", 32'(a3), 32'd9);
    step();
    issue_valid = 0;
    #1;
    chk("col_busy9", 32'(busy_vec[9]), 32'd1);

    // Full FIFO, pop and new valid in one cycle.
    pipe_we = 1; pipe_rd = 3; pipe_wd = 32'h11;
    lu_valid = 1; lu_rd = 10; lu_wd = 32'hA0;
    step();
    lu_rd = 11; lu_wd = 32'hB0;
    step();
    pipe_we = 0; pipe_rd = 0;
    lu_rd = 12; lu_wd = 32'hC0;
    #1;
    chk("fb_ready0", 32'(lu_ready), 32'd0);
    chk("fb_popA", 32'(a3), 32'd10);
    step();
    #1;
    chk("fb_ready1", 32'(lu_ready), 32'd1);
    chk("fb_popB", 32'(a3), 32'd11);
    step();
    lu_valid = 0;
    #1;
    chk("fb_popC", 32'(a3), 32'd12);
    chk("fb_wdC", wd3, 32'hC0);
    step();

    // Reset with queued entries and stall asserted.
    pipe_we = 1; pipe_rd = 3; pipe_wd = 32'h11;
    issue_valid = 1; issue_rd = 13;
    lu_valid = 1; lu_rd = 13; lu_wd = 32'hD0;
    step();
    issue_rd = 14;
    lu_rd = 14; lu_wd = 32'hE0;
    step();
    issue_valid = 0; lu_valid = 0;
    repeat (6) step();
    chk("rm_stall", 32'(stall_req), 32'd1);
    chk("rm_full", 32'(lu_ready), 32'd0);
    rst_n = 0;
    pipe_we = 0; pipe_rd = 0;
    #1;
    chk("rm_stall0", 32'(stall_req), 32'd0);
    chk("rm_busy0", busy_vec, 32'd0);
    chk("rm_ready1", 32'(lu_ready), 32'd1);
    chk("rm_we0", 32'(we3), 32'd0);
    step();
    step();
    rst_n = 1;
    step();
    step();
    chk("rm_nostale", 32'(we3), 32'd0);
    chk("rm_busy", busy_vec, 32'd0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
